// File: rtl/regfile_writeback.sv
// ============================================================================
//  Module   : regfile_writeback
//  Purpose  : ALU/LSU result writeback queue driving the register file write
//             port, with a per-register pending scoreboard for issue blocking.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_writeback #(
  parameter int XLEN       = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  output logic [31:0]     pending,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_write_data,
  output logic            rf_write_enable
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [4:0]         r_rd_mem   [FIFO_DEPTH];
  logic [XLEN-1:0]    r_data_mem [FIFO_DEPTH];
  logic [31:0]        r_pending;

  logic [c_CNT_W-1:0] w_free;
  logic               w_lsu_push;
  logic               w_alu_push;
  logic               w_pop;
  logic [c_PTR_W-1:0] w_alu_ptr;
  logic [4:0]         w_head_rd;
  logic [31:0]        w_set_mask;
  logic [31:0]        w_clr_mask;

  // No credit is given for the same-cycle pop, so ready never depends on it.
  assign w_free    = c_DEPTH - r_count;
  assign lsu_ready = (w_free != '0);
  assign alu_ready = (w_free >= (c_CNT_W'(1) + c_CNT_W'(lsu_valid)));

  // Writes to x0 complete the handshake but are never queued.
  assign w_lsu_push = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
  assign w_alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign w_pop      = (r_count != '0);
  assign w_alu_ptr  = r_wr_ptr + c_PTR_W'(w_lsu_push);
  assign w_head_rd  = r_rd_mem[r_rd_ptr];

  assign rf_write_enable = w_pop;
  assign rf_rd           = w_pop ? w_head_rd : 5'd0;
  assign rf_write_data   = w_pop ? r_data_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (w_lsu_push) begin
      r_rd_mem[r_wr_ptr]   <= lsu_rd;
      r_data_mem[r_wr_ptr] <= lsu_data;
    end
    if (w_alu_push) begin
      r_rd_mem[w_alu_ptr]   <= alu_rd;
      r_data_mem[w_alu_ptr] <= alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_count  <= r_count + c_CNT_W'(w_lsu_push) + c_CNT_W'(w_alu_push)
                  - c_CNT_W'(w_pop);
      r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_lsu_push) + c_PTR_W'(w_alu_push);
      r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_pop);
    end
  end

  // Scoreboard: x0 is never pending, so issue to x0 is always allowed.
  assign issue_ready = !r_pending[issue_rd];
  assign w_set_mask  = (issue_valid && issue_ready && (issue_rd != 5'd0))
                       ? (32'd1 << issue_rd) : 32'd0;
  assign w_clr_mask  = w_pop ? (32'd1 << w_head_rd) : 32'd0;
  assign pending     = r_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// ============================================================================
//  Module   : tb_regfile_writeback
//  Purpose  : Scoreboard bench for regfile_writeback with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_writeback;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_t;

  logic            clk;
  logic            rst;
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid, lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            issue_valid, issue_ready;
  logic [4:0]      issue_rd;
  logic [31:0]     pending;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_write_data;
  logic            rf_write_enable;

  int  checks   = 0;
  int  failures = 0;
  int  m_cnt    = 0;
  wb_t exp_q[$];

  regfile_writeback #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .pending(pending), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: every register-file write must match the oldest expected entry.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (rf_write_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected actual rd=%0d data=%h expected no write",
                   rf_rd, rf_write_data);
        end else begin
          e = exp_q.pop_front();
          chk("wb_rd", 64'(rf_rd), 64'(e.rd));
          chk("wb_data", rf_write_data, e.data);
        end
      end
    end
  end

  // One cycle of stimulus, called at posedge+1; returns at the next posedge+1
  // with all valids deasserted.
  task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                       input logic iv, input logic [4:0] ird, input logic exp_irdy,
                       output logic a_acc, output logic l_acc);
    int  free;
    int  pushes;
    logic exp_l, exp_a;
    alu_valid = av;  alu_rd = ard;  alu_data = ad;
    lsu_valid = lv;  lsu_rd = lrd;  lsu_data = ld;
    issue_valid = iv; issue_rd = ird;
    @(negedge clk);
    free  = DEPTH - m_cnt;
    exp_l = (free >= 1);
    exp_a = (free >= 1 + int'(lv));
    chk("lsu_ready", 64'(lsu_ready), 64'(exp_l));
    chk("alu_ready", 64'(alu_ready), 64'(exp_a));
    if (iv) chk("issue_ready", 64'(issue_ready), 64'(exp_irdy));
    l_acc = lv && exp_l;
    a_acc = av && exp_a;
    @(posedge clk);
    pushes = 0;
    if (l_acc && lrd != 5'd0) begin exp_q.push_back('{rd: lrd, data: ld}); pushes++; end
    if (a_acc && ard != 5'd0) begin exp_q.push_back('{rd: ard, data: ad}); pushes++; end
    m_cnt = m_cnt + pushes - ((m_cnt > 0) ? 1 : 0);
    #1;
    alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic a, l;
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, a, l);
  endtask

  initial begin
    logic a, l;
    int   li, ai;
    rst = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wen", 64'(rf_write_enable), 64'd0);
    chk("rst_rd", 64'(rf_rd), 64'd0);
    chk("rst_data", rf_write_data, 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    // ALU only
    drive(1, 5'd5, 64'hDEAD, 0, 0, 0, 0, 0, 1, a, l);
    #1;
    chk("alu_wen", 64'(rf_write_enable), 64'd1);
    chk("alu_rd", 64'(rf_rd), 64'd5);
    chk("alu_data", rf_write_data, 64'hDEAD);
    idle(1); #1;
    chk("alu_wen_after", 64'(rf_write_enable), 64'd0);

    // Simultaneous: LSU is older than ALU
    drive(1, 5'd4, 64'h22, 1, 5'd3, 64'h11, 0, 0, 1, a, l);
    #1;
    chk("sim_first_rd", 64'(rf_rd), 64'd3);
    idle(1); #1;
    chk("sim_second_rd", 64'(rf_rd), 64'd4);
    chk("sim_second_data", rf_write_data, 64'h22);
    idle(1); #1;
    chk("sim_wen_after", 64'(rf_write_enable), 64'd0);

    // Backpressure: both producers hold valid, advancing only on acceptance
    li = 0; ai = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1, 5'(16 + (ai % 8)), 64'(64'h200 + ai),
            1, 5'(8 + (li % 8)),  64'(64'h100 + li), 0, 0, 1, a, l);
      if (a) ai++;
      if (l) li++;
    end
    idle(6); #1;
    chk("bp_drained", 64'(rf_write_enable), 64'd0);

    // rd == 0 is accepted and discarded
    drive(1, 5'd0, 64'hBAD, 0, 0, 0, 0, 0, 1, a, l);
    #1;
    chk("rd0_wen", 64'(rf_write_enable), 64'd0);
    idle(1); #1;
    chk("rd0_wen_later", 64'(rf_write_enable), 64'd0);

    // Scoreboard
    drive(0, 0, 0, 0, 0, 0, 1, 5'd7, 1, a, l);
    #1;
    chk("sb_set7", 64'(pending), 64'h80);
    issue_rd = 5'd7; #1;
    chk("sb_block7", 64'(issue_ready), 64'd0);
    issue_rd = 5'd0; #1;
    chk("sb_rd0_ready", 64'(issue_ready), 64'd1);
    drive(1, 5'd7, 64'h77, 0, 0, 0, 1, 5'd0, 1, a, l);
    #1;
    chk("sb_still7", 64'(pending), 64'h80);
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 1, a, l);
    #1;
    chk("sb_clr7_set9", 64'(pending), 64'h200);

    // Reset with queued entries
    drive(1, 5'd11, 64'hB0, 1, 5'd10, 64'hA0, 0, 0, 1, a, l);
    drive(1, 5'd13, 64'hD0, 1, 5'd12, 64'hC0, 0, 0, 1, a, l);
    chk("rr_queued", 64'(exp_q.size()), 64'd3);
    rst = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    #1;
    chk("rr_wen", 64'(rf_write_enable), 64'd0);
    chk("rr_pending", 64'(pending), 64'd0);
    idle(2);
    rst = 1'b1;
    idle(3); #1;
    chk("rr_no_write", 64'(rf_write_enable), 64'd0);
    chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
